// File: rtl/pipe_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pipe_pkg: shared occupancy codes and clear-mask helper for stages    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package pipe_pkg;

  localparam logic [1:0] OCC_EMPTY = 2'd0;
  localparam logic [1:0] OCC_ONE   = 2'd1;
  localparam logic [1:0] OCC_TWO   = 2'd2;

  // Bit-level so any payload width can use it via a per-bit loop.
  function automatic logic apply_clr(input logic data, input logic mask, input logic clr);
    return clr ? (data & ~mask) : data;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_slot.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pipe_slot: one valid+data register with load, drain, flush, clr mask |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module pipe_slot #(
  parameter int         W        = 64,
  parameter logic [W-1:0] RST_VAL  = '0,
  parameter logic [W-1:0] CLR_MASK = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         load,
  input  logic         drain,
  input  logic         clr,
  input  logic [W-1:0] din,
  output logic         valid,
  output logic [W-1:0] data
);
  import pipe_pkg::*;

  logic         valid_d, valid_q;
  logic [W-1:0] data_d,  data_q;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (flush) begin
      valid_d = 1'b0;
      data_d  = RST_VAL;
    end else if (load) begin
      valid_d = 1'b1;
      for (int i = 0; i < W; i++) begin
        data_d[i] = apply_clr(din[i], CLR_MASK[i], clr);
      end
    end else if (drain) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= RST_VAL;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid = valid_q;
  assign data  = data_q;

endmodule
`default_nettype wire

// File: rtl/pipe_stage_buf.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pipe_stage_buf: elastic valid/ready stage register, optional skid    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module pipe_stage_buf #(
  parameter int           W        = 64,
  parameter int           SKID     = 1,
  parameter logic [W-1:0] RST_VAL  = '0,
  parameter logic [W-1:0] CLR_MASK = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  input  logic         in_clr,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic [1:0]   occupancy
);
  import pipe_pkg::*;

  logic         mv, sv;
  logic [W-1:0] md, sd;
  logic         in_fire, out_fire;
  logic         main_from_skid, main_load;

  assign out_fire       = mv & out_ready;
  assign in_fire        = in_valid & in_ready;
  // In TWO in_ready is low, so a skid-to-main move never collides with an input load.
  assign main_from_skid = sv & out_fire;
  assign main_load      = main_from_skid | (in_fire & (~mv | out_fire));

  pipe_slot #(
    .W        (W),
    .RST_VAL  (RST_VAL),
    .CLR_MASK (CLR_MASK)
  ) u_main (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .load  (main_load),
    .drain (out_fire),
    .clr   (main_from_skid ? 1'b0 : in_clr),
    .din   (main_from_skid ? sd : in_data),
    .valid (mv),
    .data  (md)
  );

  generate
    if (SKID != 0) begin : g_skid
      logic skid_load;
      assign skid_load = in_fire & mv & ~out_fire;

      pipe_slot #(
        .W        (W),
        .RST_VAL  (RST_VAL),
        .CLR_MASK (CLR_MASK)
      ) u_skid (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .load  (skid_load),
        .drain (out_fire),
        .clr   (in_clr),
        .din   (in_data),
        .valid (sv),
        .data  (sd)
      );

      assign in_ready = ~sv;
    end else begin : g_no_skid
      assign sv       = 1'b0;
      assign sd       = RST_VAL;
      assign in_ready = ~mv | out_ready;
    end
  endgenerate

  assign out_valid = mv;
  assign out_data  = md;

  always_comb begin
    occupancy = OCC_EMPTY;
    case ({mv, sv})
      2'b11:        occupancy = OCC_TWO;
      2'b10, 2'b01: occupancy = OCC_ONE;
      default:      occupancy = OCC_EMPTY;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_buf.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_pipe_stage_buf: directed bench for SKID=1 (table) and SKID=0      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_pipe_stage_buf;

  localparam logic [7:0] A_RST = 8'h5A;
  localparam logic [7:0] A_CLR = 8'h01;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // DUT a: SKID=1
  logic       a_flush, a_in_valid, a_in_ready, a_in_clr, a_out_valid, a_out_ready;
  logic [7:0] a_in_data, a_out_data;
  logic [1:0] a_occ;
  // DUT b: SKID=0
  logic       b_flush, b_in_valid, b_in_ready, b_in_clr, b_out_valid, b_out_ready;
  logic [7:0] b_in_data, b_out_data;
  logic [1:0] b_occ;

  pipe_stage_buf #(.W(8), .SKID(1), .RST_VAL(A_RST), .CLR_MASK(A_CLR)) u_a (
    .clk(clk), .rst_n(rst_n), .flush(a_flush),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data), .in_clr(a_in_clr),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data), .occupancy(a_occ)
  );

  pipe_stage_buf #(.W(8), .SKID(0), .RST_VAL(8'h00), .CLR_MASK(8'h00)) u_b (
    .clk(clk), .rst_n(rst_n), .flush(b_flush),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data), .in_clr(b_in_clr),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data), .occupancy(b_occ)
  );

  typedef struct {
    logic       iv;
    logic [7:0] d;
    logic       clr;
    logic       ordy;
    logic       fl;
    logic       eov;
    logic [7:0] eod;
    logic [1:0] eocc;
    logic       eir;
  } vec_t;

  vec_t vecs[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic iv, input logic [7:0] d, input logic clr, input logic ordy,
                     input logic fl, input logic eov, input logic [7:0] eod,
                     input logic [1:0] eocc, input logic eir);
    vec_t v;
    v.iv = iv; v.d = d; v.clr = clr; v.ordy = ordy; v.fl = fl;
    v.eov = eov; v.eod = eod; v.eocc = eocc; v.eir = eir;
    vecs.push_back(v);
  endtask

  logic [7:0] exp_d;

  initial begin
    // Streaming 1..8, then drain
    for (int k = 1; k <= 8; k++) add(1, 8'(k), 0, 1, 0, 1, 8'(k), 1, 1);
    add(0, 8'h00, 0, 1, 0, 0, 8'h08, 0, 1);
    // Back-pressure: 3 not accepted while full, order 1,2,3
    add(1, 8'h01, 0, 0, 0, 1, 8'h01, 1, 1);
    add(1, 8'h02, 0, 0, 0, 1, 8'h01, 2, 0);
    add(1, 8'h03, 0, 0, 0, 1, 8'h01, 2, 0);
    add(1, 8'h03, 0, 1, 0, 1, 8'h02, 1, 1);
    add(1, 8'h03, 0, 1, 0, 1, 8'h03, 1, 1);
    add(0, 8'h00, 0, 1, 0, 0, 8'h03, 0, 1);
    // Flush with both slots full, then flush dropping a real in_fire of 9
    add(1, 8'h04, 0, 0, 0, 1, 8'h04, 1, 1);
    add(1, 8'h05, 0, 0, 0, 1, 8'h04, 2, 0);
    add(1, 8'h09, 0, 0, 1, 0, A_RST, 0, 1);
    add(1, 8'h09, 0, 0, 1, 0, A_RST, 0, 1);
    add(0, 8'h00, 0, 1, 0, 0, A_RST, 0, 1);
    add(1, 8'h06, 0, 0, 0, 1, 8'h06, 1, 1);
    add(1, 8'h09, 0, 1, 1, 0, A_RST, 0, 1);
    add(0, 8'h00, 0, 1, 0, 0, A_RST, 0, 1);
    // Clear mask on main capture, plain capture, skid capture under clr
    add(1, 8'h0F, 1, 1, 0, 1, 8'h0E, 1, 1);
    add(1, 8'h0F, 0, 1, 0, 1, 8'h0F, 1, 1);
    add(1, 8'h0F, 1, 0, 0, 1, 8'h0F, 2, 0);
    add(0, 8'h00, 0, 1, 0, 1, 8'h0E, 1, 1);
    add(0, 8'hFF, 1, 1, 0, 0, 8'h0E, 0, 1);

    // Reset with activity on the inputs
    rst_n = 1'b0;
    a_flush = 0; a_in_valid = 1; a_in_data = 8'hAA; a_in_clr = 0; a_out_ready = 1;
    b_flush = 0; b_in_valid = 1; b_in_data = 8'hAA; b_in_clr = 0; b_out_ready = 1;
    repeat (2) @(posedge clk);
    #1;
    chk("a_rst_out_valid", 32'(a_out_valid), 0);
    chk("a_rst_out_data",  32'(a_out_data),  32'(A_RST));
    chk("a_rst_occupancy", 32'(a_occ),       0);
    chk("a_rst_in_ready",  32'(a_in_ready),  1);
    chk("b_rst_out_valid", 32'(b_out_valid), 0);
    chk("b_rst_out_data",  32'(b_out_data),  0);
    chk("b_rst_occupancy", 32'(b_occ),       0);
    chk("b_rst_in_ready",  32'(b_in_ready),  1);
    rst_n = 1'b1;
    a_in_valid = 0;
    b_in_valid = 0;

    // SKID=1 table
    for (int i = 0; i < vecs.size(); i++) begin
      a_in_valid  = vecs[i].iv;
      a_in_data   = vecs[i].d;
      a_in_clr    = vecs[i].clr;
      a_out_ready = vecs[i].ordy;
      a_flush     = vecs[i].fl;
      @(posedge clk);
      #1;
      chk($sformatf("a_v%0d_out_valid", i), 32'(a_out_valid), 32'(vecs[i].eov));
      chk($sformatf("a_v%0d_out_data", i),  32'(a_out_data),  32'(vecs[i].eod));
      chk($sformatf("a_v%0d_occupancy", i), 32'(a_occ),       32'(vecs[i].eocc));
      chk($sformatf("a_v%0d_in_ready", i),  32'(a_in_ready),  32'(vecs[i].eir));
    end
    a_in_valid = 0;
    a_flush    = 0;

    // SKID=0 streaming
    b_out_ready = 1;
    for (int k = 0; k < 4; k++) begin
      b_in_valid = 1;
      b_in_data  = 8'h21 + 8'(k);
      #1;
      chk($sformatf("b_stream%0d_in_ready", k), 32'(b_in_ready), 1);
      @(posedge clk);
      #1;
      chk($sformatf("b_stream%0d_out_data", k), 32'(b_out_data), 32'(8'h21 + 8'(k)));
      chk($sformatf("b_stream%0d_out_valid", k), 32'(b_out_valid), 1);
    end

    // SKID=0: in_ready follows out_ready combinationally while out_valid=1
    exp_d = 8'h24;
    for (int k = 0; k < 6; k++) begin
      b_in_valid  = 1;
      b_in_data   = 8'h30 + 8'(k);
      b_out_ready = k[0];
      #1;
      chk($sformatf("b_tog%0d_in_ready", k), 32'(b_in_ready), 32'(k[0]));
      if (k[0]) exp_d = 8'h30 + 8'(k);
      @(posedge clk);
      #1;
      chk($sformatf("b_tog%0d_occupancy", k), 32'(b_occ), 1);
      chk($sformatf("b_tog%0d_out_data", k),  32'(b_out_data), 32'(exp_d));
    end
    b_in_valid  = 0;
    b_out_ready = 1;
    @(posedge clk);
    #1;
    chk("b_drain_out_valid", 32'(b_out_valid), 0);
    chk("b_drain_out_data",  32'(b_out_data),  32'(exp_d));
    chk("b_drain_occupancy", 32'(b_occ),       0);
    chk("b_drain_in_ready",  32'(b_in_ready),  1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
